mmu_host_ctrl: RTL
==================

// Module: mmu_host_ctrl
// PURPOSE
//   Host-side sequencer for the 2x2 systolic matrix multiplier (mmu).
//   - Receives 8 operand bytes over a valid/ready byte stream and assembles A_flat/B_flat.
//   - Drives the multiplier's reset/load and times the compute window.
//   - Captures C_flat and streams the 4 result bytes back out over valid/ready.
//   - Sits between the top-level I/O pins and mmu; mmu itself never touches project outputs.
// PARAMETERS
//   COMPUTE_LAT  3  clocks from first mmu_rst-low edge until mmu_done/C_flat are valid
//   N_ELEM       4  elements per matrix; fixed for the 2x2 array, not to be overridden
// PORTS
//   clk          in   1   clock
//   rst          in   1   reset, synchronous, active-high
//   in_data      in   8   operand byte
//   in_valid     in   1   in_data valid
//   in_ready     out  1   controller accepts in_data this cycle
//   out_data     out  8   result byte
//   out_valid    out  1   out_data valid
//   out_ready    in   1   sink accepts out_data this cycle
//   mmu_A_flat   out  32  {A3,A2,A1,A0} to mmu
//   mmu_B_flat   out  32  {B3,B2,B1,B0} to mmu
//   mmu_rst      out  1   mmu reset/load strobe; registered
//   mmu_C_flat   in   32  {C3,C2,C1,C0} from mmu
//   mmu_done     in   1   mmu completion flag
//   busy         out  1   high in COMPUTE or DRAIN
//   err          out  1   sticky: mmu_done was low at the capture cycle
// BEHAVIOUR
//   Reset values:
//     - state=LOAD, idx=0, A/B/C regs=0.
//     - mmu_rst=1, in_ready=1, out_valid=0, out_data=0, busy=0, err=0.
//     - A reset mid-operation aborts in any state with no partial output; bytes already loaded are discarded.
//   Transfers occur only on valid&&ready; in every other cycle, data/index registers hold.
//   LOAD (in_ready=1, mmu_rst=1):
//     - Each accepted byte is written to slot idx, and idx increments.
//     - Slots 0-3 are A0..A3, slots 4-7 are B0..B3; A0 lands in bits [7:0].
//     - On acceptance of slot 7: idx<=0, state<=COMPUTE, mmu_rst<=0, in_ready<=0.
//   COMPUTE (mmu_rst=0, in_ready=0):
//     - cnt starts at 0 and increments every clock.
//     - mmu_done is ignored while cnt<COMPUTE_LAT; it is not reset by mmu and can be stale from a previous run.
//     - At cnt==COMPUTE_LAT: C<=mmu_C_flat, err<=err|~mmu_done, mmu_rst<=1, state<=DRAIN, out_valid<=1.
//     - mmu_rst must be high before mmu wraps to a second accumulation.
//   DRAIN (out_valid=1, mmu_rst=1):
//     - out_data=C[idx], sent in order C0,C1,C2,C3.
//     - out_data is stable while out_valid&&!out_ready.
//     - On acceptance of idx 3: out_valid<=0, idx<=0, state<=LOAD, in_ready<=1.
//     - No new operand is accepted until the drain completes.
//   Timing:
//     - Input bytes are accepted back-to-back, 1 per clock.
//     - Last input byte to first out_valid = COMPUTE_LAT+1 clocks.
//     - Output bytes are sent back-to-back when out_ready=1.
//   Arithmetic: none in this block. Results are mmu's 8-bit truncated accumulators, passed through unmodified.
//   Simultaneous events: in_valid during COMPUTE/DRAIN is ignored (in_ready=0); rst dominates every other input.
//   mmu_A_flat/mmu_B_flat are driven from the A/B registers and stay constant from the end of LOAD through DRAIN.
// TESTING
//   1. Reset, then bytes 1,2,3,4,5,6,7,8 with in_valid held high
//      -> in_ready=0 after the 8th byte; mmu_A_flat=32'h04030201, mmu_B_flat=32'h08070605.
//   2. Integration with real mmu, same stimulus
//      -> out bytes 5,6,15,18 (A0*B0, A0*B1, A2*B0, A2*B1); err=0.
//   3. Operands A={16,0,17,0}, B={16,16,0,0}
//      -> out bytes 0,0,16,16 (256 wraps to 0, 272 wraps to 16).
//   4. out_ready toggled 0/1 each cycle during DRAIN
//      -> each byte held stable until accepted; exactly 4 transfers; then in_ready=1.
//   5. Stub mmu holding mmu_done=1 throughout and with mmu_done=0 at capture
//      -> capture still occurs exactly at cnt==3; err=1 and stays sticky until rst.
//   6. rst asserted after 5 bytes loaded, and separately mid-DRAIN
//      -> all outputs return to reset values; the next 8 bytes form a fresh, correct operand set.

Source files
------------

// File: rtl/mmu_host_ctrl.sv
// -----------------------------------------------------------------------------
// mmu_host_ctrl
//   Host-side sequencer for the 2x2 systolic matrix multiplier (mmu).
//   Collects eight operand bytes (A0..A3 then B0..B3) from a valid/ready byte
//   stream, holds the multiplier in reset/load while loading, releases it for a
//   fixed compute window, captures the four result bytes and streams them back
//   out in order C0..C3. No arithmetic is done here.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   in_data/in_valid    operand byte stream in
//   in_ready            operand byte accepted this cycle (registered)
//   out_data/out_valid  result byte stream out (registered)
//   out_ready           sink accepts out_data this cycle
//   mmu_A_flat          {A3,A2,A1,A0} to mmu
//   mmu_B_flat          {B3,B2,B1,B0} to mmu
//   mmu_rst             mmu reset/load strobe (registered)
//   mmu_C_flat          {C3,C2,C1,C0} from mmu
//   mmu_done            mmu completion flag
//   busy                high while computing or draining
//   err                 sticky: mmu_done was low when results were captured
// -----------------------------------------------------------------------------
module mmu_host_ctrl #(
    parameter int COMPUTE_LAT = 3,
    parameter int N_ELEM      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] mmu_A_flat,
    output logic [31:0] mmu_B_flat,
    output logic        mmu_rst,
    input  logic [31:0] mmu_C_flat,
    input  logic        mmu_done,
    output logic        busy,
    output logic        err
);

    localparam int CNT_W = (COMPUTE_LAT < 1) ? 1 : $clog2(COMPUTE_LAT + 1);
    localparam logic [2:0]       LAST_IN  = 3'(2 * N_ELEM - 1);
    localparam logic [1:0]       LAST_OUT = 2'(N_ELEM - 1);
    localparam logic [CNT_W-1:0] CAP_CNT  = CNT_W'(COMPUTE_LAT);

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t            state_r;
    logic [2:0]        idx_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [31:0]       a_r;
    logic [31:0]       b_r;
    logic [31:0]       c_r;

    // Byte lane select out of a packed 4-byte word (lane 0 = bits [7:0]).
    function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] sel);
        logic [7:0] res;
        case (sel)
            2'd0:    res = word[7:0];
            2'd1:    res = word[15:8];
            2'd2:    res = word[23:16];
            2'd3:    res = word[31:24];
            default: res = 8'h00;
        endcase
        return res;
    endfunction

    // Replace one byte lane of a packed 4-byte word.
    function automatic logic [31:0] set_byte(input logic [31:0] word, input logic [1:0] sel,
                                             input logic [7:0] val);
        logic [31:0] res;
        res = word;
        case (sel)
            2'd0:    res[7:0]   = val;
            2'd1:    res[15:8]  = val;
            2'd2:    res[23:16] = val;
            2'd3:    res[31:24] = val;
            default: res = word;
        endcase
        return res;
    endfunction

    // Operand registers feed the multiplier directly so they stay frozen after LOAD.
    assign mmu_A_flat = a_r;
    assign mmu_B_flat = b_r;

    // Sequencer: load operands, time the compute window, drain results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_LOAD;
            idx_r     <= 3'd0;
            cnt_r     <= '0;
            a_r       <= 32'h0000_0000;
            b_r       <= 32'h0000_0000;
            c_r       <= 32'h0000_0000;
            mmu_rst   <= 1'b1;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (in_valid && in_ready) begin
                        // idx[2] picks the B half; idx[1:0] is the element slot.
                        if (idx_r[2]) begin
                            b_r <= set_byte(b_r, idx_r[1:0], in_data);
                        end else begin
                            a_r <= set_byte(a_r, idx_r[1:0], in_data);
                        end
                        if (idx_r == LAST_IN) begin
                            idx_r    <= 3'd0;
                            cnt_r    <= '0;
                            state_r  <= ST_COMPUTE;
                            mmu_rst  <= 1'b0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end else begin
                            idx_r <= idx_r + 3'd1;
                        end
                    end
                end
                ST_COMPUTE: begin
                    // mmu_done may be stale from an earlier run, so only the
                    // cycle count decides when to capture.
                    if (cnt_r == CAP_CNT) begin
                        c_r       <= mmu_C_flat;
                        err       <= err | ~mmu_done;
                        mmu_rst   <= 1'b1;
                        out_valid <= 1'b1;
                        out_data  <= mmu_C_flat[7:0];
                        idx_r     <= 3'd0;
                        state_r   <= ST_DRAIN;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (out_valid && out_ready) begin
                        if (idx_r[1:0] == LAST_OUT) begin
                            out_valid <= 1'b0;
                            out_data  <= 8'h00;
                            idx_r     <= 3'd0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                            state_r   <= ST_LOAD;
                        end else begin
                            idx_r    <= idx_r + 3'd1;
                            out_data <= get_byte(c_r, idx_r[1:0] + 2'd1);
                        end
                    end
                end
                default: begin
                    state_r   <= ST_LOAD;
                    idx_r     <= 3'd0;
                    mmu_rst   <= 1'b1;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    out_data  <= 8'h00;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
